// File: rtl/runtime_ctr_ctrl_pkg.sv
// Shared types for the runtime counter controller: host commands and FSM states.
package runtime_ctr_ctrl_pkg;

  localparam int unsigned WORD_WIDTH = 32;

  typedef logic [WORD_WIDTH-1:0] word_type;

  typedef enum logic [1:0] {
    RTC_NOP   = 2'd0,
    RTC_ARM   = 2'd1,
    RTC_ABORT = 2'd2,
    RTC_CLEAR = 2'd3
  } rtc_cmd_t;

  typedef enum logic [1:0] {
    RTC_IDLE  = 2'd0,
    RTC_ARMED = 2'd1,
    RTC_RUN   = 2'd2
  } rtc_state_t;

endpackage

// File: rtl/runtime_ctr_ctrl_if.sv
// Host-side command and result-readout channels of the runtime counter controller.
interface runtime_ctr_ctrl_if
  import runtime_ctr_ctrl_pkg::*;
#(
  parameter int unsigned CTR_WIDTH       = 32,
  parameter int unsigned INSTR_CTR_WIDTH = 16
);

  logic                       cmd_valid;
  logic                       cmd_ready;
  rtc_cmd_t                   cmd_op;
  logic                       res_valid;
  logic                       res_ready;
  logic [CTR_WIDTH-1:0]       res_cycles;
  logic [INSTR_CTR_WIDTH-1:0] res_instrs;
  logic                       res_sat;

  modport master (
    output cmd_valid, cmd_op, res_ready,
    input  cmd_ready, res_valid, res_cycles, res_instrs, res_sat
  );

  modport slave (
    input  cmd_valid, cmd_op, res_ready,
    output cmd_ready, res_valid, res_cycles, res_instrs, res_sat
  );

endinterface

// File: rtl/runtime_ctr_ctrl_sat_counter.sv
// Saturating up-counter with a sticky flag set when an increment is lost at all-ones.
// Exposes the next-cycle count so a same-cycle capture sees the final value.
module rtc_sat_counter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             load1,
  input  logic             inc,
  output logic [WIDTH-1:0] cnt_nxt_c,
  output logic             sat_nxt_c
);

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             sat_q, sat_d;

  always_comb begin
    cnt_d = cnt_q;
    sat_d = sat_q;
    if (clr) begin
      cnt_d = '0;
      sat_d = 1'b0;
    end else if (load1) begin
      cnt_d = WIDTH'(1);
      sat_d = 1'b0;
    end else if (inc) begin
      if (&cnt_q) sat_d = 1'b1;
      else        cnt_d = cnt_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
      sat_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      sat_q <= sat_d;
    end
  end

  assign cnt_nxt_c = cnt_d;
  assign sat_nxt_c = sat_d;

endmodule

// File: rtl/runtime_ctr_ctrl.sv
// Measures cycles/instructions of a TPU batch from first instr_en to host synch,
// and publishes the result through a valid/ready slot with sticky max and overrun.
module runtime_ctr_ctrl
  import runtime_ctr_ctrl_pkg::*;
#(
  parameter int unsigned CTR_WIDTH       = 32,
  parameter int unsigned INSTR_CTR_WIDTH = 16,
  parameter bit          AUTO_REARM      = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst,
  runtime_ctr_ctrl_if.slave    bus,
  input  logic                 instr_en,
  input  logic                 synch,
  output logic                 busy,
  output logic [CTR_WIDTH-1:0] max_cycles,
  output logic                 overrun
);

  rtc_state_t                 state_q, state_d;
  logic                       cmd_ready_q;
  logic                       busy_q, busy_d;
  logic                       res_valid_q, res_valid_d;
  logic [CTR_WIDTH-1:0]       res_cycles_q, res_cycles_d;
  logic [INSTR_CTR_WIDTH-1:0] res_instrs_q, res_instrs_d;
  logic                       res_sat_q, res_sat_d;
  logic [CTR_WIDTH-1:0]       max_q, max_d;
  logic                       overrun_q, overrun_d;

  logic                       cmd_fire, cnt_clr, cnt_load1, cyc_inc, ins_inc;
  logic                       run_done, clear_stats, slot_free, capture;
  logic [CTR_WIDTH-1:0]       cyc_nxt;
  logic [INSTR_CTR_WIDTH-1:0] ins_nxt;
  logic                       cyc_sat_nxt, ins_sat_nxt;

  assign cmd_fire = bus.cmd_valid && cmd_ready_q;

  rtc_sat_counter #(.WIDTH(CTR_WIDTH)) u_cyc_cnt (
    .clk(clk), .rst(rst), .clr(cnt_clr), .load1(cnt_load1), .inc(cyc_inc),
    .cnt_nxt_c(cyc_nxt), .sat_nxt_c(cyc_sat_nxt)
  );

  rtc_sat_counter #(.WIDTH(INSTR_CTR_WIDTH)) u_ins_cnt (
    .clk(clk), .rst(rst), .clr(cnt_clr), .load1(cnt_load1), .inc(ins_inc),
    .cnt_nxt_c(ins_nxt), .sat_nxt_c(ins_sat_nxt)
  );

  // Run sequencing; host commands override whatever the run would do this cycle.
  always_comb begin
    state_d     = state_q;
    cnt_clr     = 1'b0;
    cnt_load1   = 1'b0;
    cyc_inc     = 1'b0;
    ins_inc     = 1'b0;
    run_done    = 1'b0;
    clear_stats = 1'b0;
    case (state_q)
      RTC_ARMED: begin
        if (instr_en) begin
          cnt_load1 = 1'b1;
          state_d   = RTC_RUN;
        end
      end
      RTC_RUN: begin
        cyc_inc = 1'b1;
        ins_inc = instr_en;
        if (synch) begin
          run_done = 1'b1;
          state_d  = AUTO_REARM ? RTC_ARMED : RTC_IDLE;
        end
      end
      default: ;
    endcase
    if (cmd_fire) begin
      case (bus.cmd_op)
        RTC_ARM: begin
          cnt_clr  = 1'b1;
          run_done = 1'b0;
          state_d  = RTC_ARMED;
        end
        RTC_ABORT: begin
          cnt_clr  = 1'b1;
          run_done = 1'b0;
          state_d  = RTC_IDLE;
        end
        RTC_CLEAR: clear_stats = 1'b1;
        default: ;
      endcase
    end
  end

  // Result slot: a completed run lands only if the slot is empty or being drained now.
  always_comb begin
    slot_free    = !res_valid_q || bus.res_ready;
    capture      = run_done && slot_free;
    res_valid_d  = res_valid_q && !bus.res_ready;
    res_cycles_d = res_cycles_q;
    res_instrs_d = res_instrs_q;
    res_sat_d    = res_sat_q;
    max_d        = clear_stats ? '0 : max_q;
    overrun_d    = (clear_stats ? 1'b0 : overrun_q) | (run_done && !slot_free);
    if (capture) begin
      res_valid_d  = 1'b1;
      res_cycles_d = cyc_nxt;
      res_instrs_d = ins_nxt;
      res_sat_d    = cyc_sat_nxt || ins_sat_nxt;
      if (cyc_nxt > max_d) max_d = cyc_nxt;
    end
    busy_d = (state_d != RTC_IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= RTC_IDLE;
      cmd_ready_q  <= 1'b0;
      busy_q       <= 1'b0;
      res_valid_q  <= 1'b0;
      res_cycles_q <= '0;
      res_instrs_q <= '0;
      res_sat_q    <= 1'b0;
      max_q        <= '0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cmd_ready_q  <= 1'b1;
      busy_q       <= busy_d;
      res_valid_q  <= res_valid_d;
      res_cycles_q <= res_cycles_d;
      res_instrs_q <= res_instrs_d;
      res_sat_q    <= res_sat_d;
      max_q        <= max_d;
      overrun_q    <= overrun_d;
    end
  end

  assign bus.cmd_ready  = cmd_ready_q;
  assign bus.res_valid  = res_valid_q;
  assign bus.res_cycles = res_cycles_q;
  assign bus.res_instrs = res_instrs_q;
  assign bus.res_sat    = res_sat_q;
  assign busy           = busy_q;
  assign max_cycles     = max_q;
  assign overrun        = overrun_q;

endmodule

// File: tb/tb_runtime_ctr_ctrl.sv
// Bench for runtime_ctr_ctrl: three instances (default, 8-bit counter, auto-rearm).
module tb_runtime_ctr_ctrl;
  import runtime_ctr_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_errors = 0;

  logic en_a = 0, sy_a = 0, en_b = 0, sy_b = 0, en_c = 0, sy_c = 0;
  logic busy_a, busy_b, busy_c, ovr_a, ovr_b, ovr_c;
  logic [31:0] max_a, max_c;
  logic [7:0]  max_b;

  runtime_ctr_ctrl_if #(.CTR_WIDTH(32), .INSTR_CTR_WIDTH(16)) if_a ();
  runtime_ctr_ctrl_if #(.CTR_WIDTH(8),  .INSTR_CTR_WIDTH(16)) if_b ();
  runtime_ctr_ctrl_if #(.CTR_WIDTH(32), .INSTR_CTR_WIDTH(16)) if_c ();

  runtime_ctr_ctrl #(.CTR_WIDTH(32), .INSTR_CTR_WIDTH(16), .AUTO_REARM(1'b0)) dut_a (
    .clk(clk), .rst(rst), .bus(if_a.slave), .instr_en(en_a), .synch(sy_a),
    .busy(busy_a), .max_cycles(max_a), .overrun(ovr_a));
  runtime_ctr_ctrl #(.CTR_WIDTH(8), .INSTR_CTR_WIDTH(16), .AUTO_REARM(1'b0)) dut_b (
    .clk(clk), .rst(rst), .bus(if_b.slave), .instr_en(en_b), .synch(sy_b),
    .busy(busy_b), .max_cycles(max_b), .overrun(ovr_b));
  runtime_ctr_ctrl #(.CTR_WIDTH(32), .INSTR_CTR_WIDTH(16), .AUTO_REARM(1'b1)) dut_c (
    .clk(clk), .rst(rst), .bus(if_c.slave), .instr_en(en_c), .synch(sy_c),
    .busy(busy_c), .max_cycles(max_c), .overrun(ovr_c));

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cmd_a(input rtc_cmd_t op);
    if_a.cmd_valid = 1'b1; if_a.cmd_op = op; tick();
    if_a.cmd_valid = 1'b0; if_a.cmd_op = RTC_NOP;
  endtask
  task automatic cmd_b(input rtc_cmd_t op);
    if_b.cmd_valid = 1'b1; if_b.cmd_op = op; tick();
    if_b.cmd_valid = 1'b0; if_b.cmd_op = RTC_NOP;
  endtask
  task automatic cmd_c(input rtc_cmd_t op);
    if_c.cmd_valid = 1'b1; if_c.cmd_op = op; tick();
    if_c.cmd_valid = 1'b0; if_c.cmd_op = RTC_NOP;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #3 rst = 1'b0;
    #2;
    n_checks++; if (if_a.cmd_ready !== 1'b0) begin n_errors++; $display("FAIL reset_cmd_ready: got %b want 0", if_a.cmd_ready); end
    n_checks++; if (busy_a !== 1'b0 || if_a.res_valid !== 1'b0 || ovr_a !== 1'b0 || max_a !== 32'd0)
      begin n_errors++; $display("FAIL reset_outputs: busy %b valid %b ovr %b max %0d want all 0", busy_a, if_a.res_valid, ovr_a, max_a); end
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    tick();
    n_checks++; if (if_a.cmd_ready !== 1'b1) begin n_errors++; $display("FAIL release_cmd_ready: got %b want 1", if_a.cmd_ready); end
    // reset in the middle of a run
    cmd_a(RTC_ARM);
    en_a = 1'b1; tick(); en_a = 1'b0;
    repeat (3) tick();
    n_checks++; if (busy_a !== 1'b1) begin n_errors++; $display("FAIL run_busy: got %b want 1", busy_a); end
    #2 rst = 1'b0;
    #1;
    n_checks++; if (busy_a !== 1'b0 || if_a.cmd_ready !== 1'b0 || if_a.res_valid !== 1'b0)
      begin n_errors++; $display("FAIL midrun_reset: busy %b ready %b valid %b want 0 0 0", busy_a, if_a.cmd_ready, if_a.res_valid); end
    @(posedge clk); #1 rst = 1'b1;
    tick();
    n_checks++; if (if_a.cmd_ready !== 1'b1) begin n_errors++; $display("FAIL midrun_release_ready: got %b want 1", if_a.cmd_ready); end
    sy_a = 1'b1; tick(); sy_a = 1'b0;
    n_checks++; if (if_a.res_valid !== 1'b0 || busy_a !== 1'b0)
      begin n_errors++; $display("FAIL discarded_run: valid %b busy %b want 0 0", if_a.res_valid, busy_a); end
  endtask

  task automatic test_basic_run();
    cmd_a(RTC_ARM);
    en_a = 1'b1; tick(); en_a = 1'b0;
    repeat (32) tick();
    en_a = 1'b1; tick(); en_a = 1'b0;
    repeat (32) tick();
    n_checks++; if (if_a.res_valid !== 1'b0) begin n_errors++; $display("FAIL basic_early_valid: got %b want 0", if_a.res_valid); end
    sy_a = 1'b1; tick(); sy_a = 1'b0;
    n_checks++; if (if_a.res_valid !== 1'b1 || if_a.res_cycles !== 32'd67 || if_a.res_instrs !== 16'd2 || if_a.res_sat !== 1'b0)
      begin n_errors++; $display("FAIL basic_result: valid %b cyc %0d ins %0d sat %b want 1 67 2 0",
                                 if_a.res_valid, if_a.res_cycles, if_a.res_instrs, if_a.res_sat); end
    n_checks++; if (busy_a !== 1'b0 || max_a !== 32'd67)
      begin n_errors++; $display("FAIL basic_status: busy %b max %0d want 0 67", busy_a, max_a); end
    if_a.res_ready = 1'b1; tick(); if_a.res_ready = 1'b0;
    n_checks++; if (if_a.res_valid !== 1'b0) begin n_errors++; $display("FAIL basic_drain: got %b want 0", if_a.res_valid); end
  endtask

  task automatic test_saturation();
    int total;
    cmd_b(RTC_ARM);
    en_b = 1'b1; tick(); en_b = 1'b0;
    repeat (300) tick();
    sy_b = 1'b1; tick(); sy_b = 1'b0;
    total = 302;
    n_checks++; if (if_b.res_cycles !== 8'((total > 255) ? 255 : total) || if_b.res_sat !== 1'b1 || if_b.res_instrs !== 16'd1)
      begin n_errors++; $display("FAIL sat_result: cyc %0d sat %b ins %0d want 255 1 1", if_b.res_cycles, if_b.res_sat, if_b.res_instrs); end
    n_checks++; if (max_b !== 8'd255) begin n_errors++; $display("FAIL sat_max: got %0d want 255", max_b); end
    if_b.res_ready = 1'b1; tick(); if_b.res_ready = 1'b0;
    // exactly all-ones is not saturation
    cmd_b(RTC_ARM);
    en_b = 1'b1; tick(); en_b = 1'b0;
    repeat (253) tick();
    sy_b = 1'b1; tick(); sy_b = 1'b0;
    n_checks++; if (if_b.res_valid !== 1'b1 || if_b.res_cycles !== 8'd255 || if_b.res_sat !== 1'b0)
      begin n_errors++; $display("FAIL sat_boundary: valid %b cyc %0d sat %b want 1 255 0", if_b.res_valid, if_b.res_cycles, if_b.res_sat); end
  endtask

  task automatic test_overrun();
    cmd_c(RTC_ARM);
    en_c = 1'b1; tick(); en_c = 1'b0;
    repeat (8) tick();
    sy_c = 1'b1; tick(); sy_c = 1'b0;
    n_checks++; if (if_c.res_valid !== 1'b1 || if_c.res_cycles !== 32'd10 || busy_c !== 1'b1)
      begin n_errors++; $display("FAIL rearm_first: valid %b cyc %0d busy %b want 1 10 1", if_c.res_valid, if_c.res_cycles, busy_c); end
    en_c = 1'b1; tick(); en_c = 1'b0;
    repeat (3) tick();
    sy_c = 1'b1; tick(); sy_c = 1'b0;
    n_checks++; if (if_c.res_cycles !== 32'd10 || ovr_c !== 1'b1 || max_c !== 32'd10 || if_c.res_valid !== 1'b1)
      begin n_errors++; $display("FAIL overrun: cyc %0d ovr %b max %0d valid %b want 10 1 10 1", if_c.res_cycles, ovr_c, max_c, if_c.res_valid); end
    cmd_c(RTC_CLEAR);
    n_checks++; if (ovr_c !== 1'b0 || max_c !== 32'd0 || if_c.res_cycles !== 32'd10 || if_c.res_valid !== 1'b1)
      begin n_errors++; $display("FAIL clear: ovr %b max %0d cyc %0d valid %b want 0 0 10 1", ovr_c, max_c, if_c.res_cycles, if_c.res_valid); end
    if_c.res_ready = 1'b1; tick(); if_c.res_ready = 1'b0;
    n_checks++; if (if_c.res_valid !== 1'b0) begin n_errors++; $display("FAIL overrun_drain: got %b want 0", if_c.res_valid); end
  endtask

  task automatic test_abort_synch();
    cmd_a(RTC_ARM);
    en_a = 1'b1; tick(); en_a = 1'b0;
    repeat (3) tick();
    if_a.cmd_valid = 1'b1; if_a.cmd_op = RTC_ABORT; sy_a = 1'b1;
    tick();
    if_a.cmd_valid = 1'b0; if_a.cmd_op = RTC_NOP; sy_a = 1'b0;
    tick();
    n_checks++; if (if_a.res_valid !== 1'b0 || busy_a !== 1'b0)
      begin n_errors++; $display("FAIL abort_synch: valid %b busy %b want 0 0", if_a.res_valid, busy_a); end
    cmd_a(RTC_ARM);
    sy_a = 1'b1; tick(); sy_a = 1'b0;
    n_checks++; if (busy_a !== 1'b1 || if_a.res_valid !== 1'b0)
      begin n_errors++; $display("FAIL armed_synch: busy %b valid %b want 1 0", busy_a, if_a.res_valid); end
    en_a = 1'b1; tick(); en_a = 1'b0;
    repeat (2) tick();
    sy_a = 1'b1; tick(); sy_a = 1'b0;
    n_checks++; if (if_a.res_valid !== 1'b1 || if_a.res_cycles !== 32'd4 || if_a.res_instrs !== 16'd1)
      begin n_errors++; $display("FAIL post_abort_run: valid %b cyc %0d ins %0d want 1 4 1", if_a.res_valid, if_a.res_cycles, if_a.res_instrs); end
    if_a.res_ready = 1'b1; tick(); if_a.res_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    en_c = 1'b1; tick(); en_c = 1'b0;
    sy_c = 1'b1; tick(); sy_c = 1'b0;
    n_checks++; if (if_c.res_valid !== 1'b1 || if_c.res_cycles !== 32'd2 || if_c.res_instrs !== 16'd1)
      begin n_errors++; $display("FAIL b2b_first: valid %b cyc %0d ins %0d want 1 2 1", if_c.res_valid, if_c.res_cycles, if_c.res_instrs); end
    en_c = 1'b1; tick(); tick();
    sy_c = 1'b1; if_c.res_ready = 1'b1; tick();
    en_c = 1'b0; sy_c = 1'b0; if_c.res_ready = 1'b0;
    n_checks++; if (if_c.res_valid !== 1'b1 || if_c.res_cycles !== 32'd3 || if_c.res_instrs !== 16'd3 || ovr_c !== 1'b0 || max_c !== 32'd3)
      begin n_errors++; $display("FAIL b2b_second: valid %b cyc %0d ins %0d ovr %b max %0d want 1 3 3 0 3",
                                 if_c.res_valid, if_c.res_cycles, if_c.res_instrs, ovr_c, max_c); end
    if_c.res_ready = 1'b1; tick(); if_c.res_ready = 1'b0;
    n_checks++; if (if_c.res_valid !== 1'b0) begin n_errors++; $display("FAIL b2b_drain: got %b want 0", if_c.res_valid); end
  endtask

  // Reference: a run spans the first instr_en seen while armed through the synch cycle inclusive.
  task automatic test_random_runs();
    int exp_cyc, exp_ins, model_max, gap, len, hold;
    cmd_a(RTC_CLEAR);
    model_max = 0;
    for (int it = 0; it < 20; it++) begin
      cmd_a(RTC_ARM);
      gap = int'($urandom_range(0, 4));
      for (int g = 0; g < gap; g++) begin
        sy_a = 1'($urandom_range(0, 1)); tick();
      end
      sy_a = 1'b0;
      en_a = 1'b1; tick();
      exp_cyc = 1; exp_ins = 1;
      len = int'($urandom_range(0, 40));
      for (int k = 0; k < len; k++) begin
        en_a = 1'($urandom_range(0, 1)); tick();
        exp_cyc++; exp_ins += int'(en_a);
      end
      en_a = 1'($urandom_range(0, 1)); sy_a = 1'b1; tick();
      exp_cyc++; exp_ins += int'(en_a);
      en_a = 1'b0; sy_a = 1'b0;
      if (exp_cyc > model_max) model_max = exp_cyc;
      n_checks++; if (if_a.res_valid !== 1'b1 || if_a.res_cycles !== 32'(exp_cyc) || if_a.res_instrs !== 16'(exp_ins) || if_a.res_sat !== 1'b0)
        begin n_errors++; $display("FAIL rand_result[%0d]: valid %b cyc %0d ins %0d sat %b want 1 %0d %0d 0",
                                   it, if_a.res_valid, if_a.res_cycles, if_a.res_instrs, if_a.res_sat, exp_cyc, exp_ins); end
      n_checks++; if (max_a !== 32'(model_max) || busy_a !== 1'b0 || ovr_a !== 1'b0)
        begin n_errors++; $display("FAIL rand_status[%0d]: max %0d busy %b ovr %b want %0d 0 0", it, max_a, busy_a, ovr_a, model_max); end
      hold = int'($urandom_range(0, 3));
      repeat (hold) tick();
      n_checks++; if (if_a.res_valid !== 1'b1 || if_a.res_cycles !== 32'(exp_cyc))
        begin n_errors++; $display("FAIL rand_hold[%0d]: valid %b cyc %0d want 1 %0d", it, if_a.res_valid, if_a.res_cycles, exp_cyc); end
      if_a.res_ready = 1'b1; tick(); if_a.res_ready = 1'b0;
      n_checks++; if (if_a.res_valid !== 1'b0) begin n_errors++; $display("FAIL rand_drain[%0d]: got %b want 0", it, if_a.res_valid); end
    end
  endtask

  initial begin
    if_a.cmd_valid = 1'b0; if_a.cmd_op = RTC_NOP; if_a.res_ready = 1'b0;
    if_b.cmd_valid = 1'b0; if_b.cmd_op = RTC_NOP; if_b.res_ready = 1'b0;
    if_c.cmd_valid = 1'b0; if_c.cmd_op = RTC_NOP; if_c.res_ready = 1'b0;
    test_reset();
    test_basic_run();
    test_saturation();
    test_overrun();
    test_abort_synch();
    test_back_to_back();
    test_random_runs();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
